// File: rtl/hmac_i2c_pkg.sv
// -----------------------------------------------------------------------------
// hmac_i2c_pkg
// Shared constants for the I2C-to-register bridge of the HMAC/SHA1 block.
//   - Bridge FSM state encoding (as localparams and as the state enum)
//   - RD_TIMEOUT_DATA : byte returned to the I2C master when a read times out
//   - DEFAULT_ADDR_WIDTH / DEFAULT_TIMEOUT : bridge parameter defaults
// -----------------------------------------------------------------------------
package hmac_i2c_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_TIMEOUT    = 255;

    localparam logic [7:0] RD_TIMEOUT_DATA = 8'hFF;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WR_REQ  = 2'd1;
    localparam logic [1:0] ST_RD_REQ  = 2'd2;
    localparam logic [1:0] ST_RD_HOLD = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        WR_REQ  = ST_WR_REQ,
        RD_REQ  = ST_RD_REQ,
        RD_HOLD = ST_RD_HOLD
    } bridge_state_t;

endpackage

// File: rtl/i2c_reg_bridge.sv
// -----------------------------------------------------------------------------
// i2c_reg_bridge
// Sits between the I2C slave byte streams and the register block req/ack bus.
// The first received byte of a write transaction loads the register pointer;
// following bytes are written at the pointer with auto-increment. Bytes
// requested by the slave are fetched on demand from the current pointer.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   wr_tdata/tvalid/tready/tlast   received-byte stream from the slave
//   rd_tdata/tvalid/tready/tlast   transmit-byte stream to the slave
//   bus_addressed     slave is addressed (falling edge aborts a transaction)
//   reg_req/we/addr/wdata          register access request (held until ack)
//   reg_ack/rdata     access complete, read data valid with ack
//   ptr               current register pointer
//   err               sticky access-timeout flag
// -----------------------------------------------------------------------------
module i2c_reg_bridge
    import hmac_i2c_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            wr_tdata,
    input  logic                  wr_tvalid,
    output logic                  wr_tready,
    input  logic                  wr_tlast,
    output logic [7:0]            rd_tdata,
    output logic                  rd_tvalid,
    input  logic                  rd_tready,
    output logic                  rd_tlast,
    input  logic                  bus_addressed,
    output logic                  reg_req,
    output logic                  reg_we,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [7:0]            reg_wdata,
    input  logic                  reg_ack,
    input  logic [7:0]            reg_rdata,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic                  err
);

    localparam int CNT_WIDTH = 16;
    // The counter is 0 in the first request cycle, so the last allowed
    // cycle is TIMEOUT-1 and reg_req stays high for exactly TIMEOUT cycles.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    bridge_state_t         state_reg, state_next;
    logic [ADDR_WIDTH-1:0] ptr_reg, ptr_next;
    logic [ADDR_WIDTH-1:0] reg_addr_reg, reg_addr_next;
    logic [7:0]            reg_wdata_reg, reg_wdata_next;
    logic [7:0]            rd_tdata_reg, rd_tdata_next;
    logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
    logic                  expect_ptr_reg, expect_ptr_next;
    logic                  wr_tready_reg, wr_tready_next;
    logic                  rd_tvalid_reg, rd_tvalid_next;
    logic                  reg_req_reg, reg_req_next;
    logic                  reg_we_reg, reg_we_next;
    logic                  err_reg, err_next;
    logic                  addressed_reg;

    logic wr_fire;
    logic rd_fire;
    logic timeout_hit;
    logic addressed_fall;

    // wr_tready_reg is only ever high while the FSM sits in IDLE.
    assign wr_fire        = wr_tvalid && wr_tready_reg;
    assign rd_fire        = rd_tvalid_reg && rd_tready;
    assign timeout_hit    = (cnt_reg == CNT_LAST);
    assign addressed_fall = addressed_reg && !bus_addressed;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            reg_addr_reg   <= '0;
            reg_wdata_reg  <= '0;
            rd_tdata_reg   <= '0;
            cnt_reg        <= '0;
            expect_ptr_reg <= 1'b1;
            wr_tready_reg  <= 1'b0;
            rd_tvalid_reg  <= 1'b0;
            reg_req_reg    <= 1'b0;
            reg_we_reg     <= 1'b0;
            err_reg        <= 1'b0;
            addressed_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            reg_addr_reg   <= reg_addr_next;
            reg_wdata_reg  <= reg_wdata_next;
            rd_tdata_reg   <= rd_tdata_next;
            cnt_reg        <= cnt_next;
            expect_ptr_reg <= expect_ptr_next;
            wr_tready_reg  <= wr_tready_next;
            rd_tvalid_reg  <= rd_tvalid_next;
            reg_req_reg    <= reg_req_next;
            reg_we_reg     <= reg_we_next;
            err_reg        <= err_next;
            addressed_reg  <= bus_addressed;
        end
    end

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        reg_addr_next   = reg_addr_reg;
        reg_wdata_next  = reg_wdata_reg;
        rd_tdata_next   = rd_tdata_reg;
        cnt_next        = cnt_reg + 1'b1;
        expect_ptr_next = expect_ptr_reg;
        rd_tvalid_next  = rd_tvalid_reg;
        reg_req_next    = reg_req_reg;
        reg_we_next     = reg_we_reg;
        err_next        = err_reg;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (wr_fire) begin
                    expect_ptr_next = wr_tlast;
                    if (expect_ptr_reg) begin
                        ptr_next = wr_tdata[ADDR_WIDTH-1:0];
                    end else begin
                        reg_req_next   = 1'b1;
                        reg_we_next    = 1'b1;
                        reg_addr_next  = ptr_reg;
                        reg_wdata_next = wr_tdata;
                        state_next     = WR_REQ;
                    end
                end else if (rd_tready && bus_addressed) begin
                    reg_req_next  = 1'b1;
                    reg_we_next   = 1'b0;
                    reg_addr_next = ptr_reg;
                    state_next    = RD_REQ;
                end
                // A transaction that ends without a tlast byte (master gave
                // up) must not leave us expecting data on the next one.
                if (addressed_fall) begin
                    expect_ptr_next = 1'b1;
                end
            end

            WR_REQ: begin
                // A timed-out write still advances the pointer so the byte
                // stream and register addresses stay aligned.
                if (reg_ack || timeout_hit) begin
                    reg_req_next = 1'b0;
                    ptr_next     = ptr_reg + PTR_ONE;
                    state_next   = IDLE;
                    if (!reg_ack) begin
                        err_next = 1'b1;
                    end
                end
            end

            RD_REQ: begin
                if (reg_ack) begin
                    reg_req_next   = 1'b0;
                    rd_tdata_next  = reg_rdata;
                    rd_tvalid_next = 1'b1;
                    state_next     = RD_HOLD;
                end else if (timeout_hit) begin
                    reg_req_next   = 1'b0;
                    rd_tdata_next  = RD_TIMEOUT_DATA;
                    rd_tvalid_next = 1'b1;
                    err_next       = 1'b1;
                    state_next     = RD_HOLD;
                end
            end

            RD_HOLD: begin
                cnt_next = '0;
                if (rd_fire) begin
                    rd_tvalid_next = 1'b0;
                    ptr_next       = ptr_reg + PTR_ONE;
                    state_next     = IDLE;
                end else if (!bus_addressed) begin
                    // Master left before taking the byte: drop it and keep
                    // the pointer so the next read refetches this address.
                    rd_tvalid_next = 1'b0;
                    state_next     = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered so that wr_tready stays low during the reset cycle.
    assign wr_tready_next = (state_next == IDLE);

    assign wr_tready = wr_tready_reg;
    assign rd_tdata  = rd_tdata_reg;
    assign rd_tvalid = rd_tvalid_reg;
    assign rd_tlast  = 1'b0;
    assign reg_req   = reg_req_reg;
    assign reg_we    = reg_we_reg;
    assign reg_addr  = reg_addr_reg;
    assign reg_wdata = reg_wdata_reg;
    assign ptr       = ptr_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_i2c_reg_bridge
// Drives an 8-bit-address bridge and a 4-bit-address bridge in lockstep from
// the same byte streams; the bench plays the register block (random ack
// latency, or no ack for timeouts) and compares every register request,
// returned byte, pointer and error flag against a byte-level reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_reg_bridge;

    localparam int TMO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] wr_tdata;
    logic       wr_tvalid, wr_tlast, rd_tready, bus_addressed, reg_ack;
    logic [7:0] reg_rdata;

    logic       wr_tready, rd_tvalid, rd_tlast, reg_req, reg_we, err;
    logic [7:0] rd_tdata, reg_addr, reg_wdata, ptr;

    logic       n_wr_tready, n_rd_tvalid, n_rd_tlast, n_reg_req, n_reg_we, n_err;
    logic [7:0] n_rd_tdata, n_reg_wdata;
    logic [3:0] n_reg_addr, n_ptr;

    i2c_reg_bridge #(.ADDR_WIDTH(8), .TIMEOUT(TMO)) u_dut (
        .clk(clk), .rst(rst),
        .wr_tdata(wr_tdata), .wr_tvalid(wr_tvalid), .wr_tready(wr_tready), .wr_tlast(wr_tlast),
        .rd_tdata(rd_tdata), .rd_tvalid(rd_tvalid), .rd_tready(rd_tready), .rd_tlast(rd_tlast),
        .bus_addressed(bus_addressed),
        .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_ack(reg_ack), .reg_rdata(reg_rdata),
        .ptr(ptr), .err(err)
    );

    i2c_reg_bridge #(.ADDR_WIDTH(4), .TIMEOUT(TMO)) u_dut4 (
        .clk(clk), .rst(rst),
        .wr_tdata(wr_tdata), .wr_tvalid(wr_tvalid), .wr_tready(n_wr_tready), .wr_tlast(wr_tlast),
        .rd_tdata(n_rd_tdata), .rd_tvalid(n_rd_tvalid), .rd_tready(rd_tready), .rd_tlast(n_rd_tlast),
        .bus_addressed(bus_addressed),
        .reg_req(n_reg_req), .reg_we(n_reg_we), .reg_addr(n_reg_addr), .reg_wdata(n_reg_wdata),
        .reg_ack(reg_ack), .reg_rdata(reg_rdata),
        .ptr(n_ptr), .err(n_err)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    // register block contents (bench side) and the model's own copy
    logic [7:0]  mem   [256];
    logic [7:0]  m_mem [256];
    logic [7:0]  m_ptr;
    bit          m_expect_ptr;
    bit          m_err;

    // {we, addr, wdata}; wdata is 0 for reads
    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];
    logic [4:0]  obs4_q[$];

    bit ack_on    = 1'b1;
    int ack_delay = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Register block responder: logs each new request, acks after ack_delay.
    initial begin
        int age;
        age = 0;
        reg_ack = 1'b0;
        reg_rdata = 8'h00;
        forever begin
            @(negedge clk);
            reg_ack = 1'b0;
            reg_rdata = 8'($urandom);
            if (rst || !reg_req) begin
                age = 0;
            end else begin
                age++;
                if (age == 1) begin
                    obs_q.push_back({reg_we, reg_addr, reg_we ? reg_wdata : 8'h00});
                    obs4_q.push_back({n_reg_req, n_reg_addr});
                end
                if (ack_on && age == ack_delay + 1) begin
                    reg_ack = 1'b1;
                    if (reg_we) mem[reg_addr] = reg_wdata;
                    reg_rdata = mem[reg_addr];
                end
            end
        end
    end

    // Reference model for one received byte.
    task automatic model_byte(input logic [7:0] d, input bit last);
        if (m_expect_ptr) begin
            m_ptr = d;
        end else begin
            exp_q.push_back({1'b1, m_ptr, d});
            if (ack_on) m_mem[m_ptr] = d;
            else        m_err = 1'b1;
            m_ptr = m_ptr + 8'd1;
        end
        m_expect_ptr = last;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last);
        bit ok;
        @(negedge clk);
        wr_tdata = d; wr_tlast = last; wr_tvalid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (wr_tready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check_eq("wr_accept", 32'(ok), 1);
        if (ok) @(posedge clk);
        @(negedge clk);
        wr_tvalid = 1'b0; wr_tlast = 1'b0;
        $display("wr byte 0x%02h last=%0d", d, last);
        model_byte(d, last);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (wr_tready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check_eq("wr_idle", 32'(ok), 1);
    endtask

    task automatic do_read(output logic [7:0] got, output logic [7:0] got4, output int req_cycles);
        bit ok;
        @(negedge clk);
        rd_tready = 1'b1;
        ok = 1'b0;
        req_cycles = 0;
        for (int n = 0; n < 60; n++) begin
            if (reg_req) req_cycles++;
            if (rd_tvalid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check_eq("rd_valid", 32'(ok), 1);
        got  = rd_tdata;
        got4 = n_rd_tdata;
        if (ok) @(posedge clk);
        @(negedge clk);
        rd_tready = 1'b0;
    endtask

    task automatic read_check(input string tag);
        logic [7:0] exp_d, got, got4;
        int rc;
        exp_q.push_back({1'b0, m_ptr, 8'h00});
        exp_d = ack_on ? m_mem[m_ptr] : 8'hFF;
        do_read(got, got4, rc);
        $display("rd byte 0x%02h at ptr 0x%02h", got, m_ptr);
        check_eq(tag, 32'(got), 32'(exp_d));
        check_eq({tag, "_aw4"}, 32'(got4), 32'(exp_d));
        if (!ack_on) begin
            check_eq("rd_timeout_len", rc, TMO);
            m_err = 1'b1;
        end
        m_ptr = m_ptr + 8'd1;
    endtask

    task automatic abort_read();
        bit ok;
        exp_q.push_back({1'b0, m_ptr, 8'h00});
        @(negedge clk); rd_tready = 1'b1;
        @(negedge clk); rd_tready = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (rd_tvalid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check_eq("abort_hold", 32'(ok), 1);
        bus_addressed = 1'b0;
        @(negedge clk);
        check_eq("abort_rd_tvalid", 32'(rd_tvalid), 0);
        check_eq("abort_ptr", 32'(ptr), 32'(m_ptr));
        bus_addressed = 1'b1;
        $display("rd aborted at ptr 0x%02h", m_ptr);
    endtask

    task automatic bus_fall();
        @(negedge clk); bus_addressed = 1'b0;
        @(negedge clk); bus_addressed = 1'b1;
        m_expect_ptr = 1'b1;
        $display("bus_addressed pulse low in idle");
    endtask

    task automatic check_state(input string tag);
        logic [16:0] e, o;
        logic [4:0]  o4;
        check_eq({tag, "_ptr"}, 32'(ptr), 32'(m_ptr));
        check_eq({tag, "_ptr4"}, 32'(n_ptr), 32'(m_ptr[3:0]));
        check_eq({tag, "_err"}, 32'(err), 32'(m_err));
        check_eq({tag, "_nreq"}, obs_q.size(), exp_q.size());
        check_eq({tag, "_nreq4"}, obs4_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0 && obs4_q.size() > 0) begin
            e  = exp_q.pop_front();
            o  = obs_q.pop_front();
            o4 = obs4_q.pop_front();
            check_eq({tag, "_req"}, 32'(o), 32'(e));
            check_eq({tag, "_req4"}, 32'(o4), 32'({1'b1, e[11:8]}));
        end
        exp_q.delete(); obs_q.delete(); obs4_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        int n;
        rst = 1'b1;
        wr_tdata = 8'h00; wr_tvalid = 1'b0; wr_tlast = 1'b0;
        rd_tready = 1'b0; bus_addressed = 1'b0;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            mem[i] = v;
            m_mem[i] = v;
        end
        m_ptr = 8'h00; m_expect_ptr = 1'b1; m_err = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_wr_tready", 32'(wr_tready), 0);
        check_eq("rst_rd_tvalid", 32'(rd_tvalid), 0);
        check_eq("rst_rd_tdata", 32'(rd_tdata), 0);
        check_eq("rst_rd_tlast", 32'(rd_tlast), 0);
        check_eq("rst_reg_req", 32'(reg_req), 0);
        check_eq("rst_reg_we", 32'(reg_we), 0);
        check_eq("rst_reg_addr", 32'(reg_addr), 0);
        check_eq("rst_reg_wdata", 32'(reg_wdata), 0);
        check_eq("rst_ptr", 32'(ptr), 0);
        check_eq("rst_err", 32'(err), 0);
        rst = 1'b0;
        bus_addressed = 1'b1;
        @(negedge clk);
        check_eq("post_rst_wr_tready", 32'(wr_tready), 1);

        // pointer + auto-increment writes, then a fresh pointer
        send_byte(8'h10, 1'b0); send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0); send_byte(8'hA3, 1'b1);
        check_state("wr");
        send_byte(8'h40, 1'b1);
        check_state("wr_ptr");

        // pointer with tlast, then three reads
        mem[5] = 8'h55; mem[6] = 8'h66; mem[7] = 8'h77;
        m_mem[5] = 8'h55; m_mem[6] = 8'h66; m_mem[7] = 8'h77;
        send_byte(8'h05, 1'b1);
        read_check("rd0"); read_check("rd1"); read_check("rd2");
        check_state("rd");

        // pointer wrap, and narrow-pointer truncation on the 4-bit bridge
        send_byte(8'hFF, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b1);
        check_state("wrap");
        send_byte(8'h2F, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b1);
        check_state("wrap4");

        // ack on the last allowed cycle wins over the timeout
        ack_delay = TMO - 1;
        send_byte(8'h20, 1'b1);
        read_check("late_ack_rd");
        send_byte(8'h20, 1'b0); send_byte(8'h99, 1'b1);
        check_state("late_ack");
        check_eq("late_ack_err4", 32'(n_err), 0);
        ack_delay = 0;

        // byte discarded in RD_HOLD, then refetched from the same address
        send_byte(8'h60, 1'b1);
        abort_read();
        read_check("refetch");
        check_state("abort");

        // bus_addressed falling in IDLE turns the next byte into a pointer
        send_byte(8'h30, 1'b0); send_byte(8'h31, 1'b0);
        bus_fall();
        send_byte(8'h50, 1'b0);
        check_state("fall");

        // timeouts: read returns 0xFF, write is dropped, err sticks
        ack_on = 1'b0;
        read_check("rd_timeout");
        send_byte(8'h77, 1'b1);
        check_state("timeout");
        ack_on = 1'b1;

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            ack_delay = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0: begin
                    n = $urandom_range(1, 4);
                    for (int k = 0; k < n; k++)
                        send_byte(8'($urandom), (k == n - 1) ? 1'($urandom) : 1'b0);
                end
                1: begin
                    n = $urandom_range(1, 3);
                    for (int k = 0; k < n; k++) read_check("rnd_rd");
                end
                2: bus_fall();
                default: begin
                    abort_read();
                    read_check("rnd_refetch");
                end
            endcase
            check_state("rnd");
        end
        ack_delay = 0;

        // reset while a write is waiting for its ack
        bus_fall();
        send_byte(8'h11, 1'b0);
        ack_on = 1'b0;
        @(negedge clk);
        wr_tdata = 8'hC3; wr_tlast = 1'b0; wr_tvalid = 1'b1;
        check_eq("mid_wr_ready", 32'(wr_tready), 1);
        @(negedge clk);
        wr_tvalid = 1'b0;
        check_eq("mid_wr_req", 32'(reg_req), 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_reg_req", 32'(reg_req), 0);
        check_eq("mid_rst_ptr", 32'(ptr), 0);
        check_eq("mid_rst_wr_tready", 32'(wr_tready), 0);
        check_eq("mid_rst_err", 32'(err), 0);
        check_eq("mid_rst_reg_req4", 32'(n_reg_req), 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_wr_tready_up", 32'(wr_tready), 1);
        check_eq("mid_rst_wr_tready_up4", 32'(n_wr_tready), 1);
        $display("reset applied during write request");
        m_ptr = 8'h00; m_expect_ptr = 1'b1; m_err = 1'b0;
        exp_q.delete(); obs_q.delete(); obs4_q.delete();
        ack_on = 1'b1;
        send_byte(8'h22, 1'b0);
        check_state("post_rst");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/i2c_reg_bridge.md
Name: i2c_reg_bridge

Overview:
- Protocol stage directly downstream and upstream of the I2C slave.
- Consumes the slave's received-byte stream and turns it into register writes: the first byte of each write transaction is the register pointer, and later bytes write with auto-increment.
- Serves the slave's read-data stream by fetching registers on demand at the current pointer.
- Drives a simple req/ack register bus into the HMAC/SHA1 control register block.

Parameters:
- ADDR_WIDTH, 8, register address width, 1..8. Pointer = low ADDR_WIDTH bits of the pointer byte.
- TIMEOUT, 255, clock cycles to wait for reg_ack before aborting an access, 1..65535.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- wr_tdata  in  8  received byte from the I2C slave's m_axis_data.
- wr_tvalid  in  1  received byte valid.
- wr_tready  out  1  bridge accepts the received byte.
- wr_tlast  in  1  last byte of the write transaction (stop or repeated start seen).
- rd_tdata  out  8  byte to transmit, to the slave's s_axis_data.
- rd_tvalid  out  1  transmit byte valid.
- rd_tready  in  1  slave requests a byte (held high while clock-stretching).
- rd_tlast  out  1  tied 0.
- bus_addressed  in  1  slave addressed status.
- reg_req  out  1  register access request.
- reg_we  out  1  1 = write, 0 = read.
- reg_addr  out  ADDR_WIDTH  register address.
- reg_wdata  out  8  write data.
- reg_ack  in  1  access complete; reg_rdata valid in the same cycle.
- reg_rdata  in  8  read data.
- ptr  out  ADDR_WIDTH  current pointer.
- err  out  1  sticky timeout flag; cleared only by rst.

Behaviour:
- Reset values: wr_tready=0, rd_tvalid=0, rd_tdata=0, reg_req=0, reg_we=0, reg_addr=0, reg_wdata=0, ptr=0, err=0. The internal flag expect_ptr=1 and the state is IDLE.
- FSM states: IDLE, WR_REQ, RD_REQ, RD_HOLD.
- wr_tready is 1 only in IDLE. The wr handshake is wr_tvalid && wr_tready.
- IDLE, wr handshake with expect_ptr=1:
  - ptr <= tdata[ADDR_WIDTH-1:0]; expect_ptr <= wr_tlast.
  - No register access; stay in IDLE.
- IDLE, wr handshake with expect_ptr=0:
  - reg_req=1, reg_we=1, reg_addr=ptr, reg_wdata=tdata.
  - expect_ptr <= wr_tlast; go to WR_REQ.
- IDLE, no wr handshake, rd_tready=1 && bus_addressed=1: reg_req=1, reg_we=0, reg_addr=ptr; go to RD_REQ. A wr handshake takes priority over a read request in the same cycle.
- WR_REQ:
  - Hold the request signals stable until reg_ack.
  - On reg_ack: reg_req=0, ptr <= ptr+1 (wraps modulo 2^ADDR_WIDTH), go to IDLE.
- RD_REQ:
  - On reg_ack: rd_tdata <= reg_rdata, rd_tvalid <= 1, reg_req=0, go to RD_HOLD.
  - Registered output, so rd_tvalid rises 1 cycle after reg_ack.
- RD_HOLD:
  - On rd_tvalid && rd_tready: rd_tvalid <= 0, ptr <= ptr+1 (wrap), go to IDLE.
  - If bus_addressed=0 while still holding: discard the byte. rd_tvalid <= 0, ptr unchanged, go to IDLE. The next read re-fetches the same address. This deliberately breaks AXIS valid stability; the slave ignores the stream outside an addressed read.
- Timeout:
  - A cycle counter runs in WR_REQ and RD_REQ and resets on entry.
  - When it reaches TIMEOUT without reg_ack: reg_req <= 0 and err <= 1.
  - Write timeout: the byte is dropped, ptr still increments, go to IDLE.
  - Read timeout: return rd_tdata=8'hFF and go to RD_HOLD.
  - reg_ack in the same cycle as the timeout: the ack wins, err is not set.
- reg_ack outside WR_REQ/RD_REQ is ignored.
- A falling edge of bus_addressed in IDLE sets expect_ptr <= 1. This covers aborted transactions that end with no tlast byte.
- A wr byte with tlast while expect_ptr=1 only sets ptr. This supports the pointer-write + repeated-start + read pattern.
- rst in any state: immediate return to reset values next cycle. reg_req drops without waiting for ack.
- Throughput: 1 byte per 2 cycles with zero-wait reg_ack, far faster than the I2C byte time.

Decomposition:
- Shared package (hmac_i2c_pkg): FSM state encoding localparams; RD_TIMEOUT_DATA = 8'hFF; default ADDR_WIDTH/TIMEOUT constants.
- No sub-module. The timeout counter is inline.
- Top level instantiates i2c_slave + i2c_reg_bridge + the register block.

Test Plan:
- Write: bytes 0x10,0xA1,0xA2,0xA3 (tlast on 0xA3) -> reg writes (0x10,0xA1),(0x11,0xA2),(0x12,0xA3); ptr=0x13; the next byte 0x40 is treated as a pointer (ptr=0x40, no write).
- Read: pointer byte 0x05 with tlast; regs 0x05..0x07 = 0x55,0x66,0x77; rd_tready asserted 3 times with bus_addressed=1 -> rd_tdata 0x55,0x66,0x77 in order; ptr=0x08.
- Wrap: pointer 0xFF then data 0x01,0x02 (tlast) -> writes at 0xFF then 0x00; ptr=0x01. With ADDR_WIDTH=4, pointer 0x2F -> ptr=0xF, writes at 0xF then 0x0.
- Timeout: TIMEOUT=8, reg_ack never asserted on a read -> reg_req drops after 8 cycles, rd_tdata=0xFF, err=1 and stays 1 through later good accesses. Ack on exactly cycle 8 -> err stays 0.
- Abort in RD_HOLD: byte held, bus_addressed falls before rd_tready -> rd_tvalid=0, ptr unchanged; the next addressed read re-issues reg_addr=same ptr. A falling bus_addressed in IDLE makes the next byte a pointer.
- Reset mid-WR_REQ with reg_ack withheld -> next cycle reg_req=0, ptr=0, wr_tready=0; the next cycle wr_tready=1; the first byte afterwards is a pointer.
